// File: rtl/room_navigator_pkg.sv
// zork_pkg: shared direction codes, wall bit positions, FSM states and decode helpers.
package zork_pkg;
    typedef enum logic [2:0] {
        DIR_UP    = 3'b000,
        DIR_LEFT  = 3'b010,
        DIR_NONE  = 3'b100,
        DIR_RIGHT = 3'b101,
        DIR_DOWN  = 3'b111
    } dir_t;
    localparam int WALL_N = 3;
    localparam int WALL_S = 2;
    localparam int WALL_E = 1;
    localparam int WALL_W = 0;
    typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;
    // Illegal codes fall through to "no move", same as NONE.
    function automatic logic is_move(logic [2:0] d);
        return d == DIR_UP || d == DIR_DOWN || d == DIR_LEFT || d == DIR_RIGHT;
    endfunction
    function automatic logic [1:0] wall_side(dir_t d);
        return d == DIR_UP ? 2'(WALL_N) : d == DIR_DOWN ? 2'(WALL_S) :
               d == DIR_RIGHT ? 2'(WALL_E) : 2'(WALL_W);
    endfunction
endpackage

// File: rtl/room_navigator_if.sv
// room_navigator_if: move handshake, wall-config write port and position/result outputs.
// master drives dir/valid/cfg_*, slave (the navigator) drives ready, position, pulses, count.
interface room_navigator_if #(parameter int XW = 3, parameter int YW = 2);
    logic [2:0]    dir_i;
    logic          valid_i;
    logic          ready_o;
    logic          cfg_we_i;
    logic [XW-1:0] cfg_x_i;
    logic [YW-1:0] cfg_y_i;
    logic [3:0]    cfg_walls_i;
    logic [XW-1:0] positionx_o;
    logic [YW-1:0] positiony_o;
    logic          moved_o;
    logic          blocked_o;
    logic [15:0]   move_count_o;
    modport master (output dir_i, valid_i, cfg_we_i, cfg_x_i, cfg_y_i, cfg_walls_i,
                    input ready_o, positionx_o, positiony_o, moved_o, blocked_o, move_count_o);
    modport slave (input dir_i, valid_i, cfg_we_i, cfg_x_i, cfg_y_i, cfg_walls_i,
                   output ready_o, positionx_o, positiony_o, moved_o, blocked_o, move_count_o);
endinterface

// File: rtl/room_navigator_wall_map.sv
// wall_map: per-cell 4-bit {N,S,E,W} wall register file.
// Ports: clk, rst_n (sync active-low clear), we/wx/wy/wdata write port, rx/ry -> rdata comb read.
module wall_map #(
    parameter int GRID_W = 8,
    parameter int GRID_H = 4,
    localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1,
    localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [XW-1:0] wx,
    input  logic [YW-1:0] wy,
    input  logic [3:0]    wdata,
    input  logic [XW-1:0] rx,
    input  logic [YW-1:0] ry,
    output logic [3:0]    rdata
);
    localparam int CELLS = GRID_W * GRID_H;
    localparam int AW = $clog2(CELLS);
    logic [3:0] cells [CELLS];
    logic [AW-1:0] widx, ridx;
    logic in_range;
    always_comb begin
        in_range = int'(wx) < GRID_W && int'(wy) < GRID_H;
        widx = AW'(wy) * AW'(GRID_W) + AW'(wx);
        ridx = AW'(ry) * AW'(GRID_W) + AW'(rx);
        rdata = cells[ridx];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CELLS; i++) cells[i] <= '0;
        end else if (we && in_range) begin
            cells[widx] <= wdata;
        end
    end
endmodule

// File: rtl/room_navigator.sv
// room_navigator: grid walker that accepts one move per held direction, honouring walls and edges.
// Ports: clk_50MHz_i, rst_sync_la_i (sync active-low), bus (room_navigator_if.slave).
module room_navigator import zork_pkg::*; #(
    parameter int GRID_W  = 8,
    parameter int GRID_H  = 4,
    parameter int START_X = 7,
    parameter int START_Y = 3,
    parameter int WRAP    = 0,
    localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1,
    localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
    input logic clk_50MHz_i,
    input logic rst_sync_la_i,
    room_navigator_if.slave bus
);
    state_t state, state_nx;
    dir_t dir_q;
    logic [3:0] walls_q, cur_walls;
    logic [XW-1:0] pos_x, tgt_x;
    logic [YW-1:0] pos_y, tgt_y;
    logic [15:0] count;
    logic ready, accept, hold_exit, blk, off_edge, moved, blocked;
    logic x_min, x_max, y_min, y_max;

    wall_map #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_map (
        .clk(clk_50MHz_i), .rst_n(rst_sync_la_i), .we(bus.cfg_we_i),
        .wx(bus.cfg_x_i), .wy(bus.cfg_y_i), .wdata(bus.cfg_walls_i),
        .rx(pos_x), .ry(pos_y), .rdata(cur_walls)
    );

    always_ff @(posedge clk_50MHz_i) begin
        if (!rst_sync_la_i) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (accept ? EVAL : IDLE) :
                   state == EVAL ? HOLD : (hold_exit ? IDLE : HOLD);
    end

    always_comb begin
        ready = state == IDLE;
        accept = ready && bus.valid_i && is_move(bus.dir_i);
        // A held direction must be released before the next move is accepted.
        hold_exit = !bus.valid_i || !is_move(bus.dir_i);
        x_min = pos_x == '0;
        x_max = pos_x == XW'(GRID_W - 1);
        y_min = pos_y == '0;
        y_max = pos_y == YW'(GRID_H - 1);
        tgt_x = dir_q == DIR_RIGHT ? (x_max ? '0 : pos_x + XW'(1)) :
                dir_q == DIR_LEFT ? (x_min ? XW'(GRID_W - 1) : pos_x - XW'(1)) : pos_x;
        tgt_y = dir_q == DIR_DOWN ? (y_max ? '0 : pos_y + YW'(1)) :
                dir_q == DIR_UP ? (y_min ? YW'(GRID_H - 1) : pos_y - YW'(1)) : pos_y;
        off_edge = (dir_q == DIR_RIGHT && x_max) || (dir_q == DIR_LEFT && x_min) ||
                   (dir_q == DIR_DOWN && y_max) || (dir_q == DIR_UP && y_min);
        blk = walls_q[wall_side(dir_q)] || (WRAP == 0 && off_edge);
    end

    // Walls are latched at accept so a same-cycle config write cannot affect this move.
    always_ff @(posedge clk_50MHz_i) begin
        if (!rst_sync_la_i) begin
            dir_q <= DIR_NONE;
            walls_q <= '0;
            pos_x <= XW'(START_X);
            pos_y <= YW'(START_Y);
            moved <= 1'b0;
            blocked <= 1'b0;
            count <= '0;
        end else begin
            if (accept) begin
                dir_q <= dir_t'(bus.dir_i);
                walls_q <= cur_walls;
            end
            moved <= state == EVAL && !blk;
            blocked <= state == EVAL && blk;
            if (state == EVAL && !blk) begin
                pos_x <= tgt_x;
                pos_y <= tgt_y;
                if (count != 16'hFFFF) count <= count + 16'd1;
            end
        end
    end

    assign bus.ready_o = ready;
    assign bus.positionx_o = pos_x;
    assign bus.positiony_o = pos_y;
    assign bus.moved_o = moved;
    assign bus.blocked_o = blocked;
    assign bus.move_count_o = count;
endmodule

// File: doc/room_navigator.md
ROOM_NAVIGATOR -- requirements
Module: room_navigator

Interface
REQ-001 Parameter GRID_W, default 8, number of map columns (2..16).
REQ-002 Parameter GRID_H, default 4, number of map rows (2..16).
REQ-003 Parameter START_X, default 7, column loaded at reset.
REQ-004 Parameter START_Y, default 3, row loaded at reset.
REQ-005 Parameter WRAP, default 0; 0 = blocked at grid edge, 1 = wrap to opposite edge.
REQ-006 Derived XW = clog2(GRID_W) and YW = clog2(GRID_H), each minimum 1.
REQ-007 clk_50MHz_i  in  1  system clock; all logic on rising edge.
REQ-008 rst_sync_la_i  in  1  reset, synchronous, active-low.
REQ-009 dir_i  in  3  move code: UP=000, DOWN=111, RIGHT=101, LEFT=010, NONE=100; other codes are treated as NONE.
REQ-010 valid_i  in  1  dir_i is qualified.
REQ-011 ready_o  out  1  block can accept a move this cycle.
REQ-012 cfg_we_i  in  1  wall-map write strobe.
REQ-013 cfg_x_i / cfg_y_i  in  XW / YW  cell address for the write.
REQ-014 cfg_walls_i  in  4  blocked sides {N,S,E,W}; 1 = wall.
REQ-015 positionx_o / positiony_o  out  XW / YW  current registered position.
REQ-016 moved_o / blocked_o  out  1 / 1  one-cycle result pulses.
REQ-017 move_count_o  out  16  successful moves since reset, saturating at 0xFFFF.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, EVAL, HOLD; ready_o = 1 only in IDLE.
REQ-019 Accept: IDLE with valid_i=1 and dir_i a non-NONE legal code SHALL latch dir_i and the current cell's walls, then go to EVAL.
REQ-020 EVAL SHALL last one cycle and compute the target cell: UP y-1, DOWN y+1, LEFT x-1, RIGHT x+1.
REQ-021 The move SHALL be blocked if the latched wall bit for the travel side (UP=N, DOWN=S, RIGHT=E, LEFT=W) is 1.
REQ-022 The move SHALL also be blocked when WRAP=0 and the target leaves 0..GRID_W-1 / 0..GRID_H-1.
REQ-023 With WRAP=1, x=GRID_W-1 moving RIGHT SHALL give x=0, and x=0 moving LEFT SHALL give GRID_W-1; y wraps the same way over GRID_H.
REQ-024 On leaving EVAL, the position SHALL update (if not blocked) and exactly one of moved_o/blocked_o SHALL pulse in the same cycle, 2 cycles after acceptance; the FSM then enters HOLD.
REQ-025 HOLD SHALL return to IDLE only after a cycle with valid_i=0 or dir_i decoding as NONE, so a held direction moves exactly once.
REQ-026 A config write SHALL take effect on the next edge; an accept and a write to the same cell in the same cycle SHALL evaluate the old walls.
REQ-027 Config writes to out-of-range addresses SHALL be ignored.
REQ-028 move_count_o SHALL increment on every moved_o pulse and hold at 0xFFFF.

Reset
REQ-029 With rst_sync_la_i=0 at an edge: position = (START_X, START_Y); state IDLE; moved_o = blocked_o = 0; move_count_o = 0; all walls = 0000.
REQ-030 Reset SHALL override an in-flight EVAL/HOLD with no result pulse, and SHALL override a same-cycle config write.

Structure
REQ-031 Direction codes, the 4-bit wall bit positions and the state encoding SHALL live in shared package zork_pkg.
REQ-032 The wall storage SHALL be sub-module wall_map: GRID_W*GRID_H x 4-bit register file, one write port, one combinational read port.

Verification
REQ-033 8x4, WRAP=0, start (7,3): LEFT held 500 cycles -> one moved_o, position (6,3), count 1, ready_o stays 0 until dir_i=NONE.
REQ-034 At (7,3), RIGHT -> blocked_o pulse, position (7,3); same with WRAP=1 -> moved_o, position (0,3).
REQ-035 Write cell (6,3) walls=0001, then LEFT from (6,3) -> blocked_o; UP -> (6,2).
REQ-036 Reset asserted in the EVAL cycle -> no pulse, position (7,3), count 0, walls cleared.
REQ-037 Accept LEFT at (6,3) while writing 0001 to (6,3) in the same cycle -> moved_o to (5,3); a later LEFT from (6,3) -> blocked_o.
REQ-038 dir_i=011 with valid_i=1 in IDLE -> no accept, ready_o stays 1, no pulse.
